// File: rtl/sobel_stream_if.sv
// sobel_stream_if: pixel-in / result-out stream bundle plus run-time controls.
// The master modport drives pixels and controls; the slave modport is the filter.
interface sobel_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             mode;
    logic [PIX_W+3:0] thresh;
    logic             frame_done;

    modport master (
        output s_valid, s_data, out_ready, mode, thresh,
        input  s_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  s_valid, s_data, out_ready, mode, thresh,
        output s_ready, out_valid, out_data, frame_done
    );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: raster-order streaming 3x3 Sobel filter using two line buffers.
// Optional feature macro: SOBEL_STREAM_REPLICATE_EN selects border replicate
// instead of the default zero padding for out-of-image pixels.
module sobel_stream #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512
) (
    input logic           clk,
    input logic           reset,
    sobel_stream_if.slave bus
);
    localparam int unsigned GW = PIX_W + 4;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef SOBEL_STREAM_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    typedef enum logic [2:0] {S_FILL, S_RUN, S_EOL, S_FLUSH, S_LAST} state_e;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [2:0][PIX_W-1:0] col_t;  // [0] top, [1] middle, [2] bottom row

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    col_t            win_a_q, win_a_d;    // column c-2 of the current window
    col_t            win_b_q, win_b_d;    // column c-1 of the current window
    logic            mode_q, mode_d;
    logic [GW-1:0]   thresh_q, thresh_d;
    logic            out_valid_q, out_valid_d;
    pix_t            out_data_q, out_data_d;
    logic            frame_done_q, frame_done_d;
    pix_t            lb_a_q [IMG_W];      // row r-2
    pix_t            lb_b_q [IMG_W];      // row r-1

    logic            s_ready_c, acc_c, can_load_c, load_c, lb_we_c;
    col_t            rd_col_c, col_l_c, col_m_c, col_r_c;
    logic            top_out_c, bot_out_c, left_out_c, right_out_c;
    logic [CW-1:0]   idx_l_c, idx_r_c;
    logic signed [GW-1:0] gx_c, gy_c;
    logic [GW-1:0]   mag_c;
    pix_t            res_c;

    function automatic logic [GW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    function automatic col_t pad_rows(input col_t x, input logic top_out, input logic bot_out);
        col_t y;
        y = x;
        if (top_out) y[0] = REPLICATE ? x[1] : '0;
        if (bot_out) y[2] = REPLICATE ? x[1] : '0;
        return y;
    endfunction

    // Input handshake: RUN only accepts when the output register can take a result
    always_comb begin
        can_load_c = !out_valid_q || bus.out_ready;
        s_ready_c  = 1'b0;
        case (state_q)
            S_FILL:  s_ready_c = 1'b1;
            S_RUN:   s_ready_c = can_load_c;
            default: s_ready_c = 1'b0;
        endcase
        acc_c = bus.s_valid && s_ready_c;
    end

    // Window assembly: pick left/centre/right columns for the result being produced, then pad
    always_comb begin
        idx_l_c     = (col_q == '0) ? col_q : col_q - CW'(1);
        idx_r_c     = (col_q == COL_LAST) ? col_q : col_q + CW'(1);
        rd_col_c    = {bus.s_data, lb_b_q[col_q], lb_a_q[col_q]};
        col_l_c     = win_a_q;
        col_m_c     = win_b_q;
        col_r_c     = rd_col_c;
        top_out_c   = (row_q == RW'(1));
        bot_out_c   = 1'b0;
        left_out_c  = (col_q == CW'(1));
        right_out_c = 1'b0;
        case (state_q)
            S_EOL: begin
                col_r_c     = win_b_q;
                left_out_c  = 1'b0;
                right_out_c = 1'b1;
            end
            S_FLUSH: begin
                col_l_c     = {lb_b_q[idx_l_c], lb_b_q[idx_l_c], lb_a_q[idx_l_c]};
                col_m_c     = {lb_b_q[col_q], lb_b_q[col_q], lb_a_q[col_q]};
                col_r_c     = {lb_b_q[idx_r_c], lb_b_q[idx_r_c], lb_a_q[idx_r_c]};
                top_out_c   = 1'b0;
                bot_out_c   = 1'b1;
                left_out_c  = (col_q == '0);
                right_out_c = (col_q == COL_LAST);
            end
            default: ;
        endcase
        col_l_c = pad_rows(col_l_c, top_out_c, bot_out_c);
        col_m_c = pad_rows(col_m_c, top_out_c, bot_out_c);
        col_r_c = pad_rows(col_r_c, top_out_c, bot_out_c);
        if (left_out_c)  col_l_c = REPLICATE ? col_m_c : '0;
        if (right_out_c) col_r_c = REPLICATE ? col_m_c : '0;
    end

    // Gradients, magnitude and output mapping
    always_comb begin
        gx_c  = signed'(wsum(col_l_c[0], col_l_c[1], col_l_c[2]))
              - signed'(wsum(col_r_c[0], col_r_c[1], col_r_c[2]));
        gy_c  = signed'(wsum(col_l_c[0], col_m_c[0], col_r_c[0]))
              - signed'(wsum(col_l_c[2], col_m_c[2], col_r_c[2]));
        mag_c = (gx_c[GW-1] ? unsigned'(-gx_c) : unsigned'(gx_c))
              + (gy_c[GW-1] ? unsigned'(-gy_c) : unsigned'(gy_c));
        if (mode_q) res_c = (|mag_c[GW-1:PIX_W]) ? '1 : mag_c[PIX_W-1:0];
        else        res_c = (mag_c <= thresh_q) ? '1 : '0;
    end

    // Next state, counters, window shift and output register update
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_a_d      = win_a_q;
        win_b_d      = win_b_q;
        mode_d       = mode_q;
        thresh_d     = thresh_q;
        frame_done_d = 1'b0;
        load_c       = 1'b0;
        lb_we_c      = 1'b0;
        case (state_q)
            S_FILL: if (acc_c) begin
                lb_we_c = 1'b1;
                if (col_q == '0) begin
                    mode_d   = bus.mode;
                    thresh_d = bus.thresh;
                end
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    row_d   = RW'(1);
                    state_d = S_RUN;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_RUN: if (acc_c) begin
                lb_we_c = 1'b1;
                win_a_d = win_b_q;
                win_b_d = rd_col_c;
                load_c  = (col_q != '0);
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = S_EOL;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_EOL: if (can_load_c) begin
                load_c = 1'b1;
                if (row_q == ROW_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = S_RUN;
                end
            end
            S_FLUSH: if (can_load_c) begin
                load_c = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = S_LAST;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_LAST: if (out_valid_q && bus.out_ready) begin
                frame_done_d = 1'b1;
                row_d        = '0;
                col_d        = '0;
                state_d      = S_FILL;
            end
            default: state_d = S_FILL;
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_c) begin
            out_valid_d = 1'b1;
            out_data_d  = res_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FILL;
            row_q        <= '0;
            col_q        <= '0;
            win_a_q      <= '0;
            win_b_q      <= '0;
            mode_q       <= 1'b0;
            thresh_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_a_q      <= win_a_d;
            win_b_q      <= win_b_d;
            mode_q       <= mode_d;
            thresh_q     <= thresh_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers: the older row shifts up as the new pixel lands in the same column
    always_ff @(posedge clk) begin
        if (lb_we_c) begin
            lb_a_q[col_q] <= lb_b_q[col_q];
            lb_b_q[col_q] <= bus.s_data;
        end
    end

    assign bus.s_ready    = s_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed frames checked against a pixel-level Sobel model.
module tb_sobel_stream;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int TW    = PIX_W + 4;
`ifdef SOBEL_STREAM_REPLICATE_EN
    localparam int FLAT_M1_00 = 0;
    localparam int FLAT_M1_03 = 0;
    localparam int FLAT_M0_00 = 255;
`else
    localparam int FLAT_M1_00 = 255;
    localparam int FLAT_M1_03 = 255;
    localparam int FLAT_M0_00 = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sobel_stream_if #(.PIX_W(PIX_W)) bus();

    sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int img [IMG_H][IMG_W];
    int exp_r [NPIX];
    int got [NPIX];
    int ref_got [NPIX];
    int res_idx = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc0 = 0;
    bit first_pending = 1'b0;
    int fd_count = 0;
    int fd_cyc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Pixel model: out-of-image pixels are zero or the nearest edge pixel
    function automatic int px(input int r, input int c);
`ifdef SOBEL_STREAM_REPLICATE_EN
        if (r < 0) r = 0;
        if (r > IMG_H - 1) r = IMG_H - 1;
        if (c < 0) c = 0;
        if (c > IMG_W - 1) c = IMG_W - 1;
        return img[r][c];
`else
        if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 0;
        return img[r][c];
`endif
    endfunction

    function automatic int model(input int r, input int c, input int md, input int th);
        int gx, gy, mag;
        gx = (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1)) - (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1));
        gy = (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1)) - (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md != 0) return (mag > 255) ? 255 : mag;
        return (mag <= th) ? 255 : 0;
    endfunction

    // Output ready: always 1 or a coin flip each cycle
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every consumed result, the stall rule and frame_done
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                res_idx = 0;
            end else begin
                if (first_pending && bus.s_valid && bus.s_ready) begin
                    t_acc0 = cyc + 1;
                    first_pending = 1'b0;
                end
                if (bus.out_valid && !bus.out_ready)
                    check("s_ready_while_stalled", int'(bus.s_ready), 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (res_idx >= NPIX) begin
                        check("extra_result", res_idx, NPIX - 1);
                    end else begin
                        got[res_idx] = int'(bus.out_data);
                        check($sformatf("result_%0d_%0d", res_idx / IMG_W, res_idx % IMG_W),
                              int'(bus.out_data), exp_r[res_idx]);
                        res_idx++;
                    end
                end
                if (bus.frame_done) begin
                    fd_count++;
                    fd_cyc = cyc;
                end
            end
        end
    end

    task automatic run_frame(input int md, input int th, input int limit, input bit wait_done);
        bit acc;
        int guard;
        for (int k = 0; k < NPIX; k++) exp_r[k] = model(k / IMG_W, k % IMG_W, md, th);
        res_idx = 0;
        fd_count = 0;
        first_pending = 1'b1;
        bus.mode = 1'(md);
        bus.thresh = TW'(th);
        for (int k = 0; k < limit; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data = PIX_W'(img[k / IMG_W][k % IMG_W]);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                check("accept_timeout", 0, 1);
                break;
            end
            // the captured controls must not follow later changes
            bus.mode = ~1'(md);
            bus.thresh = TW'($urandom_range(0, 4095));
        end
        bus.s_valid = 1'b0;
        if (wait_done) begin
            guard = 0;
            while (fd_count == 0 && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
            repeat (4) @(posedge clk);
            #1;
            check("frame_done_pulses", fd_count, 1);
            check("result_count", res_idx, NPIX);
        end
    endtask

    task automatic fill_flat(input int v);
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = $urandom_range(0, 255);
    endtask

    initial begin
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.mode = 1'b0;
        bus.thresh = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_ready", int'(bus.s_ready), 1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Flat image, saturated magnitude, frame timing
        fill_flat(100);
        run_frame(1, 0, NPIX, 1'b1);
        check("flat_m1_0_0", got[0], FLAT_M1_00);
        check("flat_m1_0_3", got[3], FLAT_M1_03);
        check("flat_m1_1_3", got[1*IMG_W + 3], 0);
        check("flat_m1_2_4", got[2*IMG_W + 4], 0);
        check("frame_length", fd_cyc - t_acc0, 43);

        // Flat image, binary edge map
        run_frame(0, 255, NPIX, 1'b1);
        check("flat_m0_1_1", got[1*IMG_W + 1], 255);
        check("flat_m0_0_0", got[0], FLAT_M0_00);

        // Vertical step between columns 3 and 4
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (c >= 4) ? 10 : 0;
        run_frame(1, 0, NPIX, 1'b1);
        for (int r = 1; r <= 2; r++) begin
            check($sformatf("step_%0d_2", r), got[r*IMG_W + 2], 0);
            check($sformatf("step_%0d_3", r), got[r*IMG_W + 3], 40);
            check($sformatf("step_%0d_4", r), got[r*IMG_W + 4], 40);
            check($sformatf("step_%0d_5", r), got[r*IMG_W + 5], 0);
        end

        // Random image: full-rate reference, then random back-pressure must match it
        fill_rand();
        run_frame(1, 0, NPIX, 1'b1);
        for (int k = 0; k < NPIX; k++) ref_got[k] = got[k];
        rand_ready = 1'b1;
        run_frame(1, 0, NPIX, 1'b1);
        for (int k = 0; k < NPIX; k++) check($sformatf("bitmatch_%0d", k), got[k], ref_got[k]);
        run_frame(0, 300, NPIX, 1'b1);

        // Reset after 13 accepted pixels, then a clean frame
        fill_rand();
        run_frame(1, 0, 13, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_out_valid", int'(bus.out_valid), 0);
        check("midreset_s_ready", int'(bus.s_ready), 1);
        check("midreset_out_data", int'(bus.out_data), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        fill_rand();
        run_frame(1, 0, NPIX, 1'b1);
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end
endmodule
